// File: rtl/reg_sram_pkg.sv
// Shared encodings for the register/data SRAM initiator: command codes,
// controller states and the SRAM data width.
package reg_sram_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        CMD_READ  = 2'b00,
        CMD_WRITE = 2'b01,
        CMD_FILL  = 2'b10,
        CMD_RSVD  = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RSP,
        WR,
        FILL
    } state_e;

endpackage

// File: rtl/REG_sram.sv
// Single-port word SRAM: synchronous write, combinational read.
module REG_sram #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_write,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_write) begin
            mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_addr];

endmodule

// File: rtl/reg_sram_initiator.sv
// SRAM initiator: serves single READ/WRITE and block FILL commands from a
// valid/ready request channel; read data returns on a valid/ready response channel.
module reg_sram_initiator
    import reg_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [1:0]            i_req_cmd,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    input  logic [ADDR_WIDTH-1:0] i_req_len,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic                  o_done,
    output logic                  o_err,
    output logic [ADDR_WIDTH-1:0] o_sram_addr,
    output logic                  o_sram_write,
    output logic [DATA_WIDTH-1:0] o_sram_wdata,
    input  logic [DATA_WIDTH-1:0] i_sram_rdata
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    state_e                state;
    state_e                state_next;
    cmd_e                  req_cmd;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] count;

    assign req_cmd = cmd_e'(i_req_cmd);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    unique case (req_cmd)
                        CMD_READ:  state_next = RD;
                        CMD_WRITE: state_next = WR;
                        CMD_FILL:  state_next = FILL;
                        CMD_RSVD:  state_next = IDLE;
                        default:   state_next = IDLE;
                    endcase
                end
            end
            RD:      state_next = RSP;
            RSP:     state_next = i_rsp_ready ? IDLE : RSP;
            WR:      state_next = IDLE;
            FILL:    state_next = (count == '0) ? IDLE : FILL;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = (state == IDLE) && !i_rst;
        accept      = i_req_valid && o_req_ready;
    end

    // SRAM-side lines come only from these registers, so request inputs never
    // reach the SRAM combinationally.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_sram_addr  <= '0;
            o_sram_wdata <= '0;
            o_sram_write <= 1'b0;
            o_rsp_valid  <= 1'b0;
            o_rsp_data   <= '0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            count        <= '0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        o_sram_addr  <= i_req_addr;
                        o_sram_wdata <= i_req_wdata;
                        o_sram_write <= (req_cmd == CMD_WRITE) || (req_cmd == CMD_FILL);
                        count        <= i_req_len;
                        o_err        <= (req_cmd == CMD_RSVD);
                    end
                end
                RD: begin
                    o_rsp_data  <= i_sram_rdata;
                    o_rsp_valid <= 1'b1;
                end
                RSP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                    end
                end
                WR: begin
                    o_sram_write <= 1'b0;
                end
                FILL: begin
                    if (count == '0) begin
                        o_sram_write <= 1'b0;
                        o_done       <= 1'b1;
                    end else begin
                        o_sram_addr <= o_sram_addr + ADDR_ONE;
                        count       <= count - ADDR_ONE;
                    end
                end
                default: begin
                    o_sram_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_sram_initiator.sv
// Self-checking bench for reg_sram_initiator driving a REG_sram instance,
// checked against a word-array reference of the memory contents.
module tb_reg_sram_initiator;

    localparam int AW = 8;
    localparam logic [1:0] C_RD = 2'b00;
    localparam logic [1:0] C_WR = 2'b01;
    localparam logic [1:0] C_FL = 2'b10;
    localparam logic [1:0] C_RS = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_cmd;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic [AW-1:0] req_len;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_data;
    logic          done;
    logic          err;
    logic [AW-1:0] sram_addr;
    logic          sram_write;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;

    always #5 clk = ~clk;

    reg_sram_initiator #(.ADDR_WIDTH(AW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_cmd(req_cmd),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_len(req_len),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
        .o_done(done), .o_err(err),
        .o_sram_addr(sram_addr), .o_sram_write(sram_write), .o_sram_wdata(sram_wdata),
        .i_sram_rdata(sram_rdata)
    );

    REG_sram #(.ADDR_WIDTH(AW)) sram (
        .i_clk(clk), .i_write(sram_write), .i_addr(sram_addr),
        .i_wdata(sram_wdata), .o_rdata(sram_rdata)
    );

    logic [31:0] ref_mem [256];
    int n_checks = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    logic [31:0] got;

    always @(posedge clk) begin
        if (sram_write === 1'b1) wr_cnt++;
    end

    typedef struct {
        logic [1:0]  cmd;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction starting in an idle cycle; expectations come from
    // the memory array and the command timing rules.
    task automatic run_op(input logic [1:0] c, input logic [7:0] a, input logic [31:0] d,
                          input logic [7:0] l, input int hold, output logic [31:0] rd);
        int start;
        logic [7:0] pa;
        rd = '0;
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_cmd = c; req_addr = a; req_wdata = d; req_len = l;
        start = wr_cnt;
        step();
        // Busy-time garbage on the request lines must be ignored.
        req_cmd = 2'($urandom); req_addr = 8'($urandom); req_wdata = $urandom; req_len = 8'($urandom);
        req_valid = (c != C_RS);
        case (c)
            C_RD: begin
                check("rd_addr", sram_addr, a);
                check("rd_nowrite", sram_write, 0);
                check("rd_busy", req_ready, 0);
                check("rd_valid_early", rsp_valid, 0);
                step();
                check("rd_valid", rsp_valid, 1);
                check("rd_data", rsp_data, ref_mem[a]);
                rd = rsp_data;
                for (int i = 0; i < hold; i++) begin
                    step();
                    check("bp_valid", rsp_valid, 1);
                    check("bp_data", rsp_data, rd);
                    check("bp_busy", req_ready, 0);
                end
                rsp_ready = 1'b1;
                step();
                rsp_ready = 1'b0;
                req_valid = 1'b0;
                check("rd_released", rsp_valid, 0);
                check("rd_ready_again", req_ready, 1);
                check("rd_wr_count", 32'(wr_cnt - start), 0);
            end
            C_WR: begin
                check("wr_strobe", sram_write, 1);
                check("wr_addr", sram_addr, a);
                check("wr_data", sram_wdata, d);
                check("wr_busy", req_ready, 0);
                step();
                req_valid = 1'b0;
                check("wr_strobe_off", sram_write, 0);
                check("wr_ready_again", req_ready, 1);
                check("wr_count", 32'(wr_cnt - start), 1);
                ref_mem[a] = d;
            end
            C_FL: begin
                pa = a;
                for (int k = 0; k <= int'(l); k++) begin
                    check("fill_strobe", sram_write, 1);
                    check("fill_addr", sram_addr, pa);
                    check("fill_data", sram_wdata, d);
                    check("fill_done_early", done, 0);
                    ref_mem[pa] = d;
                    pa = pa + 8'd1;
                    step();
                end
                req_valid = 1'b0;
                check("fill_done", done, 1);
                check("fill_strobe_off", sram_write, 0);
                check("fill_ready_again", req_ready, 1);
                check("fill_no_err", err, 0);
                check("fill_count", 32'(wr_cnt - start), 32'(int'(l) + 1));
            end
            default: begin
                check("rsvd_err", err, 1);
                check("rsvd_nowrite", sram_write, 0);
                check("rsvd_ready", req_ready, 1);
                check("rsvd_no_done", done, 0);
                step();
                check("rsvd_err_pulse", err, 0);
                check("rsvd_count", 32'(wr_cnt - start), 0);
            end
        endcase
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int start;
        logic [1:0] c;
        rst = 1'b1; req_valid = 1'b0; req_cmd = '0; req_addr = '0;
        req_wdata = '0; req_len = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_write", sram_write, 0);
        check("rst_addr", sram_addr, 0);
        check("rst_wdata", sram_wdata, 0);
        check("rst_rsp_data", rsp_data, 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", req_ready, 1);
        step();

        // Full-depth fill establishes known memory contents.
        run_op(C_FL, 8'h00, 32'h0, 8'hFF, 0, got);

        tbl[0] = '{C_WR, 8'h10, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{C_RD, 8'h10, 32'h0,        32'hDEADBEEF};
        tbl[2] = '{C_WR, 8'h00, 32'h00001234, 32'h0};
        tbl[3] = '{C_WR, 8'hFF, 32'hCAFEF00D, 32'h0};
        tbl[4] = '{C_RD, 8'hFF, 32'h0,        32'hCAFEF00D};
        tbl[5] = '{C_RD, 8'h00, 32'h0,        32'h00001234};
        tbl[6] = '{C_RD, 8'h05, 32'h0,        32'h00000000};
        for (int i = 0; i < 7; i++) begin
            run_op(tbl[i].cmd, tbl[i].addr, tbl[i].wdata, 8'h0, 0, got);
            if (tbl[i].cmd == C_RD) check("tbl_rdata", got, tbl[i].exp);
        end

        run_op(C_RD, 8'h10, 32'h0, 8'h0, 5, got);
        check("bp_rdata", got, 32'hDEADBEEF);

        run_op(C_FL, 8'hFE, 32'hA5A5A5A5, 8'd3, 0, got);
        step();
        check("done_pulse_width", done, 0);
        run_op(C_RD, 8'hFE, 32'h0, 8'h0, 0, got);
        check("wrap_fe", got, 32'hA5A5A5A5);
        run_op(C_RD, 8'h01, 32'h0, 8'h0, 0, got);
        check("wrap_01", got, 32'hA5A5A5A5);
        run_op(C_RD, 8'h02, 32'h0, 8'h0, 0, got);
        check("wrap_02_untouched", got, 32'h0);

        run_op(C_FL, 8'h20, 32'h13579BDF, 8'd0, 0, got);
        run_op(C_RD, 8'h21, 32'h0, 8'h0, 0, got);
        check("single_fill_21", got, 32'h0);

        run_op(C_RS, 8'h30, 32'hFFFFFFFF, 8'h0, 0, got);
        run_op(C_RD, 8'h30, 32'h0, 8'h0, 0, got);
        check("rsvd_untouched", got, 32'h0);

        // Reset coincides with the second FILL write edge.
        req_valid = 1'b1; req_cmd = C_FL; req_addr = 8'h40; req_wdata = 32'h77777777; req_len = 8'd9;
        start = wr_cnt;
        step();
        req_valid = 1'b0;
        check("mf_strobe", sram_write, 1);
        step();
        rst = 1'b1;
        step();
        check("mf_strobe_off", sram_write, 0);
        check("mf_no_done", done, 0);
        check("mf_ready_in_rst", req_ready, 0);
        rst = 1'b0;
        #1;
        check("mf_ready_after", req_ready, 1);
        step();
        check("mf_no_done_late", done, 0);
        check("mf_count", 32'(wr_cnt - start), 2);
        ref_mem[8'h40] = 32'h77777777;
        ref_mem[8'h41] = 32'h77777777;
        run_op(C_RD, 8'h41, 32'h0, 8'h0, 0, got);
        run_op(C_RD, 8'h42, 32'h0, 8'h0, 0, got);

        // Pending response discarded by reset.
        req_valid = 1'b1; req_cmd = C_RD; req_addr = 8'h10;
        step();
        req_valid = 1'b0;
        step();
        check("pend_valid", rsp_valid, 1);
        rst = 1'b1;
        step();
        check("pend_dropped", rsp_valid, 0);
        rst = 1'b0;
        step();
        check("pend_idle_ready", req_ready, 1);
        check("pend_still_dropped", rsp_valid, 0);

        for (int n = 0; n < 60; n++) begin
            c = 2'($urandom_range(0, 3));
            run_op(c, 8'($urandom), $urandom, 8'($urandom_range(0, 7)),
                   int'($urandom_range(0, 3)), got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
